udp_tx_channel_mux: RTL

- Parametrised multi-channel front end for the UDP transmit path.
- Merges NUM_CH user UDP streams, each carrying a connection ID, into one stream, with round-robin arbitration at packet granularity.
- For each packet, issues one reverse lookup to the connection manager. A hit forwards the packet to ethernet_tx with the resolved destination MAC/IP/port as stable sideband. A miss drops the packet and increments that channel's drop counter.

---
 rtl/udp_tx_pkg.sv | 23 ++
 rtl/udp_tx_channel_mux_rr_arbiter.sv | 41 ++++
 rtl/udp_tx_channel_mux.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/udp_tx_pkg.sv
// Shared types for the UDP transmit channel mux.
// Sideband widths, FSM encoding and resolved destination bundle.
package udp_tx_pkg;

   localparam int MAC_ADDR_WIDTH = 48;
   localparam int IP_ADDR_WIDTH  = 32;
   localparam int UDP_PORT_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP_REQ,
      LOOKUP_WAIT,
      FORWARD,
      DROP
   } mux_state_t;

   typedef struct packed {
      logic [MAC_ADDR_WIDTH-1:0] mac;
      logic [IP_ADDR_WIDTH-1:0]  ip;
      logic [UDP_PORT_WIDTH-1:0] port;
   } dst_info_t;

endpackage

// File: rtl/udp_tx_channel_mux_rr_arbiter.sv
// Round-robin channel picker; the pointer only moves on advance_i,
// so a channel keeps priority order across whole packets.
module rr_arbiter #(
   parameter int NUM_CH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_CH-1:0]         req_i,
   input  logic                      advance_i,
   output logic [$clog2(NUM_CH)-1:0] grant_idx_o,
   output logic                      grant_valid_o
);

   localparam int IW = $clog2(NUM_CH);

   logic [IW-1:0] last_q;
   logic [IW-1:0] idx;

   // Nearest requester after last_q wins.
   always_comb begin
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      idx           = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = IW'((int'(last_q) + k) % NUM_CH);
         if (!grant_valid_o && req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= IW'(NUM_CH - 1);
      end else if (advance_i && grant_valid_o) begin
         last_q <= grant_idx_o;
      end
   end

endmodule

// File: rtl/udp_tx_channel_mux.sv
// Multi-channel UDP tx front end: per-packet arbitration, one
// reverse lookup per packet, forward on hit, drop and count on miss.
module udp_tx_channel_mux
   import udp_tx_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DATA_WIDTH     = 512,
   parameter int CONN_ID_WIDTH  = 32,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                             tx_axis_aclk,
   input  logic                             tx_axis_reset,
   input  logic [NUM_CH-1:0]                s_axis_tvalid,
   output logic [NUM_CH-1:0]                s_axis_tready,
   input  logic [NUM_CH-1:0]                s_axis_tlast,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [NUM_CH*DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [NUM_CH*CONN_ID_WIDTH-1:0]  s_axis_connection_id,
   output logic                             m01_axis_rv_lookup_valid,
   output logic [CONN_ID_WIDTH-1:0]         m01_axis_rv_lookup_connectionId,
   input  logic                             m01_axis_rv_lookup_ready,
   input  logic                             s01_axis_rv_lookup_valid,
   output logic                             s01_axis_rv_lookup_ready,
   input  logic                             s01_axis_rv_lookup_hit,
   input  logic [47:0]                      s01_axis_rv_lookup_macAddr,
   input  logic [31:0]                      s01_axis_rv_lookup_ipAddr,
   input  logic [15:0]                      s01_axis_rv_lookup_udpPort,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]          m_axis_tkeep,
   output logic [47:0]                      m_axis_dst_macAddr,
   output logic [31:0]                      m_axis_dst_ipAddr,
   output logic [15:0]                      m_axis_dst_udpPort,
   output logic [$clog2(NUM_CH)-1:0]        m_axis_channel,
   output logic [NUM_CH*DROP_CNT_WIDTH-1:0] drop_count,
   output logic                             busy
);

   localparam int CW = $clog2(NUM_CH);
   localparam int KW = DATA_WIDTH / 8;

   mux_state_t                state_q;
   logic [CW-1:0]             grant_q;
   logic [CW-1:0]             chan_q;
   logic [CONN_ID_WIDTH-1:0]  id_q;
   dst_info_t                 dst_q;
   logic [DROP_CNT_WIDTH-1:0] drop_q [NUM_CH];
   logic [DROP_CNT_WIDTH-1:0] drop_d;

   logic [DATA_WIDTH-1:0]     data_a [NUM_CH];
   logic [KW-1:0]             keep_a [NUM_CH];
   logic [CONN_ID_WIDTH-1:0]  id_a   [NUM_CH];

   logic [CW-1:0] arb_idx;
   logic          arb_valid;
   logic          arb_adv;
   logic          fwd;
   logic          beat_vld;
   logic          beat_last;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign data_a[c] = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
      assign keep_a[c] = s_axis_tkeep[c*KW +: KW];
      assign id_a[c]   = s_axis_connection_id[c*CONN_ID_WIDTH +: CONN_ID_WIDTH];
      assign drop_count[c*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_q[c];
   end

   assign arb_adv = (state_q == IDLE);

   rr_arbiter #(
      .NUM_CH(NUM_CH)
   ) u_arb (
      .clk_i         (tx_axis_aclk),
      .rst_i         (tx_axis_reset),
      .req_i         (s_axis_tvalid),
      .advance_i     (arb_adv),
      .grant_idx_o   (arb_idx),
      .grant_valid_o (arb_valid)
   );

   assign fwd       = (state_q == FORWARD);
   assign beat_vld  = s_axis_tvalid[grant_q];
   assign beat_last = s_axis_tlast[grant_q];

   always_comb begin
      s_axis_tready = '0;
      if (fwd) begin
         s_axis_tready[grant_q] = m_axis_tready;
      end else if (state_q == DROP) begin
         s_axis_tready[grant_q] = 1'b1;
      end
   end

   always_comb begin
      drop_d = drop_q[grant_q];
      if (drop_d != '1) begin
         drop_d = drop_d + 1'b1;
      end
   end

   assign m_axis_tvalid = fwd & beat_vld;
   assign m_axis_tlast  = fwd & beat_last;
   assign m_axis_tdata  = fwd ? data_a[grant_q] : '0;
   assign m_axis_tkeep  = fwd ? keep_a[grant_q] : '0;

   assign m01_axis_rv_lookup_valid        = (state_q == LOOKUP_REQ);
   assign m01_axis_rv_lookup_connectionId = id_q;
   assign s01_axis_rv_lookup_ready        = (state_q == LOOKUP_WAIT);

   assign m_axis_dst_macAddr = dst_q.mac;
   assign m_axis_dst_ipAddr  = dst_q.ip;
   assign m_axis_dst_udpPort = dst_q.port;
   assign m_axis_channel     = chan_q;
   assign busy               = (state_q != IDLE);

   always_ff @(posedge tx_axis_aclk) begin
      if (tx_axis_reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         chan_q  <= '0;
         id_q    <= '0;
         dst_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            drop_q[c] <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  grant_q <= arb_idx;
                  id_q    <= id_a[arb_idx];
                  state_q <= LOOKUP_REQ;
               end
            end
            LOOKUP_REQ: begin
               if (m01_axis_rv_lookup_ready) begin
                  state_q <= LOOKUP_WAIT;
               end
            end
            LOOKUP_WAIT: begin
               if (s01_axis_rv_lookup_valid) begin
                  if (s01_axis_rv_lookup_hit) begin
                     dst_q <= '{mac:  s01_axis_rv_lookup_macAddr,
                                ip:   s01_axis_rv_lookup_ipAddr,
                                port: s01_axis_rv_lookup_udpPort};
                     chan_q  <= grant_q;
                     state_q <= FORWARD;
                  end else begin
                     drop_q[grant_q] <= drop_d;
                     state_q         <= DROP;
                  end
               end
            end
            FORWARD: begin
               if (beat_vld && m_axis_tready && beat_last) begin
                  state_q <= IDLE;
               end
            end
            DROP: begin
               if (beat_vld && beat_last) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
